// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the sync_fifo_param family.
//
// Contents:
//   DEF_*       default parameter values used by the top.
//   ptr_w()     pointer width for a given depth.
//   cnt_w()     occupancy-count width for a given depth (holds 0..DEPTH).
//   params_ok() elaboration-time legality check for a parameter set.
package sync_fifo_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_DEPTH     = 16;
  localparam int DEF_AF_THRESH = 12;
  localparam int DEF_AE_THRESH = 4;

  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // One extra bit so that a completely full FIFO (count == DEPTH) is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit params_ok(input int data_w, input int depth,
                                   input int af_thresh, input int ae_thresh);
    bit pow2;
    pow2 = (depth >= 2) && ((depth & (depth - 1)) == 0);
    return (data_w >= 1) && pow2 &&
           (af_thresh >= 1) && (af_thresh <= depth) &&
           (ae_thresh >= 0) && (ae_thresh <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage for sync_fifo_param: DEPTH x DATA_W array, one write port and one
// registered read port.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset (rdata only).
//   we, waddr, wdata  write port, written on posedge when we=1.
//   re, raddr       read port; rdata <= mem[raddr] on posedge when re=1.
//   rdata           registered read data, holds when re=0.
//
// The array itself is deliberately not reset so it maps onto plain RAM.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ptr_w(DEPTH)-1:0]  waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     re,
  input  logic [ptr_w(DEPTH)-1:0]  raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, programmable
// almost-full/almost-empty flags and sticky overflow/underflow flags.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset.
//   wr_req_, wr_data  active-low write request and its data.
//   rd_req_         active-low read request.
//   rd_data, rd_valid registered read data, valid one cycle after an accepted read.
//   full, empty, almost_full, almost_empty  occupancy flags (from registered count).
//   count           current occupancy, 0..DEPTH.
//   overflow, underflow sticky error flags; clr_err clears them (a new error wins).
//   max_level       high-water mark when SYNC_FIFO_HWM_EN is defined, else tied 0.
//
// Build option: `define SYNC_FIFO_HWM_EN to enable the high-water-mark register.
//
// Handshake: a request is accepted in the cycle it is asserted (low) if the
// FIFO can take it, judged only from the flags as they stand before the edge:
// write accepted when !wr_req_ && !full, read accepted when !rd_req_ && !empty.
// A rejected request is dropped (not retried) and raises the sticky error flag.
// An accepted read produces rd_valid=1 with its data on the following cycle.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEF_AF_THRESH,
  parameter int AE_THRESH = DEF_AE_THRESH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_req_,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    rd_req_,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    rd_valid,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow,
  input  logic                    clr_err,
  output logic [$clog2(DEPTH):0]  max_level
);

  localparam int ADDR_W = ptr_w(DEPTH);
  localparam int CNT_W  = cnt_w(DEPTH);

  if (!params_ok(DATA_W, DEPTH, AF_THRESH, AE_THRESH)) begin : g_param_err
    $error("sync_fifo_param: illegal parameters DATA_W=%0d DEPTH=%0d AF_THRESH=%0d AE_THRESH=%0d",
           DATA_W, DEPTH, AF_THRESH, AE_THRESH);
  end

  logic              wr_acc;
  logic              rd_acc;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;

  assign wr_acc = !wr_req_ && !full;
  assign rd_acc = !rd_req_ && !empty;

  sync_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .re    (rd_acc),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // DEPTH is a power of two, so plain binary increment wraps correctly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_acc) rd_ptr <= rd_ptr + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
    end
  end

  // Flags come from the registered count only, so no request input has a
  // combinational path to them.
  assign full         = (count == CNT_W'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CNT_W'(AF_THRESH));
  assign almost_empty = (count <= CNT_W'(AE_THRESH));

  // A new error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (!wr_req_ && full)       overflow <= 1'b1;
      else if (clr_err)           overflow <= 1'b0;
      if (!rd_req_ && empty)      underflow <= 1'b1;
      else if (clr_err)           underflow <= 1'b0;
    end
  end

`ifdef SYNC_FIFO_HWM_EN
  // High-water mark tracks the registered count; clr_err restarts it from
  // the present occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_level <= '0;
    end else if (clr_err) begin
      max_level <= count;
    end else if (count > max_level) begin
      max_level <= count;
    end
  end
`else
  assign max_level = '0;
`endif

endmodule
